// File: rtl/temporizador_regressivo_pkg.sv
// Shared types and constants for the countdown timer.
// Holds the state encoding, the display range limit and the load saturation helper.
package temporizador_regressivo_pkg;

    localparam int unsigned VALOR_W = 7;
    localparam logic [VALOR_W-1:0] VALOR_MAX = 7'd99;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2,
        FIM      = 2'd3
    } estado_t;

    // Clamp a load value to the two-digit display range.
    function automatic logic [VALOR_W-1:0] saturar(input logic [VALOR_W-1:0] v);
        return (v > VALOR_MAX) ? VALOR_MAX : v;
    endfunction

endpackage

// File: rtl/temporizador_regressivo_if.sv
// Control/status bundle between the timer and its user (panel logic or bench).
// master: drives carga, valor_carga, start, pausa; reads valor, fim, rodando.
// slave : the timer itself.
interface temporizador_regressivo_if;
    import temporizador_regressivo_pkg::*;

    logic               carga;
    logic [VALOR_W-1:0] valor_carga;
    logic               start;
    logic               pausa;
    logic [VALOR_W-1:0] valor;
    logic               fim;
    logic               rodando;

    modport master (
        output carga, valor_carga, start, pausa,
        input  valor, fim, rodando
    );

    modport slave (
        input  carga, valor_carga, start, pausa,
        output valor, fim, rodando
    );

endinterface

// File: rtl/temporizador_regressivo_divisor_tick.sv
// divisor_tick: prescaler producing a one-cycle tick every DIV enabled cycles.
// Ports: clk, reset (sync, active-high), en (advance count), clr (force count to 0),
//        tick (high when count==DIV-1 and en; combinational from the count register).
// The count holds whenever en is low, so a paused timer resumes mid-period.
module divisor_tick #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == CNT_MAX) ? '0 : count + CNT_W'(1);
        end
    end

    assign tick = en && !clr && (count == CNT_MAX);

endmodule

// File: rtl/temporizador_regressivo.sv
// temporizador_regressivo: 0..99 countdown timer with start/pause and load.
// Ports: clk, reset (sync, active-high), bus (slave modport: carga, valor_carga,
//        start, pausa in; valor, fim, rodando out, all registered).
// Parameters: CLK_FREQ, TICK_HZ -> DIV = CLK_FREQ/TICK_HZ cycles per decrement.
// Build option: define AUTO_RELOAD_EN to reload from the last loaded value on
// reaching 0 instead of stopping (fim then pulses for one cycle).
module temporizador_regressivo
    import temporizador_regressivo_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned TICK_HZ  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    temporizador_regressivo_if.slave bus
);

    localparam int unsigned DIV = CLK_FREQ / TICK_HZ;

    estado_t            estado;
    logic [VALOR_W-1:0] valor_r;
    logic               fim_r;
    logic               rodando_r;
    logic               contar;
    logic               limpar;
    logic               tick;
`ifdef AUTO_RELOAD_EN
    logic [VALOR_W-1:0] recarga;
`endif

    // Prescaler advances while running, and also on the resuming start edge
    // from PAUSADO so the held phase continues without a lost cycle.
    assign contar = !bus.carga && !bus.pausa &&
                    ((estado == CONTANDO) || ((estado == PAUSADO) && bus.start));
    assign limpar = bus.carga ||
                    ((estado == OCIOSO) && bus.start && (valor_r != '0));

    divisor_tick #(.DIV(DIV)) u_divisor (
        .clk   (clk),
        .reset (reset),
        .en    (contar),
        .clr   (limpar),
        .tick  (tick)
    );

    // State, count and status flags; rodando tracks the next state being CONTANDO.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= OCIOSO;
            valor_r   <= '0;
            fim_r     <= 1'b0;
            rodando_r <= 1'b0;
`ifdef AUTO_RELOAD_EN
            recarga   <= '0;
`endif
        end else if (bus.carga) begin
            estado    <= OCIOSO;
            valor_r   <= saturar(bus.valor_carga);
            fim_r     <= 1'b0;
            rodando_r <= 1'b0;
`ifdef AUTO_RELOAD_EN
            recarga   <= saturar(bus.valor_carga);
`endif
        end else begin
            // fim is sticky only in FIM; elsewhere it is a one-edge pulse.
            fim_r <= (estado == FIM);
            if (estado == OCIOSO) begin
                if (bus.start && (valor_r != '0)) begin
                    estado    <= CONTANDO;
                    rodando_r <= 1'b1;
                end
            end else if (contar) begin
                estado    <= CONTANDO;
                rodando_r <= 1'b1;
                if (tick) begin
                    if (valor_r == 7'd1) begin
`ifdef AUTO_RELOAD_EN
                        if (recarga != '0) begin
                            valor_r <= recarga;
                            fim_r   <= 1'b1;
                        end else begin
                            valor_r   <= '0;
                            fim_r     <= 1'b1;
                            estado    <= FIM;
                            rodando_r <= 1'b0;
                        end
`else
                        valor_r   <= '0;
                        fim_r     <= 1'b1;
                        estado    <= FIM;
                        rodando_r <= 1'b0;
`endif
                    end else begin
                        valor_r <= valor_r - 7'd1;
                    end
                end
            end else if ((estado == CONTANDO) && bus.pausa) begin
                estado    <= PAUSADO;
                rodando_r <= 1'b0;
            end
        end
    end

    assign bus.valor   = valor_r;
    assign bus.fim     = fim_r;
    assign bus.rodando = rodando_r;

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Bench for temporizador_regressivo with CLK_FREQ=4, TICK_HZ=1 (DIV=4).
// Directed scenarios with literal expectations, then random stimulus against a
// behavioural model that tracks remaining count and elapsed running cycles.
module tb_temporizador_regressivo;

    localparam int DIV = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    // Reference model state
    int m_val;
    int m_reload;
    int m_elapsed;
    bit m_run;
    bit m_paused;
    bit m_done;
    bit m_fim;

    temporizador_regressivo_if bus ();

    temporizador_regressivo #(
        .CLK_FREQ (4),
        .TICK_HZ  (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int v;
        if (reset) begin
            m_val = 0; m_reload = 0; m_elapsed = 0;
            m_run = 0; m_paused = 0; m_done = 0; m_fim = 0;
        end else if (bus.carga) begin
            v = int'(bus.valor_carga);
            if (v > 99) v = 99;
            m_val = v; m_reload = v; m_elapsed = 0;
            m_run = 0; m_paused = 0; m_done = 0; m_fim = 0;
        end else begin
            m_fim = m_done;
            if (!m_run && !m_paused && !m_done) begin
                if (bus.start && m_val > 0) begin
                    m_run = 1;
                    m_elapsed = 0;
                end
            end else if (m_run && bus.pausa) begin
                m_run = 0;
                m_paused = 1;
            end else if (m_run || (m_paused && bus.start && !bus.pausa)) begin
                m_run = 1;
                m_paused = 0;
                m_elapsed++;
                if (m_elapsed == DIV) begin
                    m_elapsed = 0;
                    if (m_val > 1) begin
                        m_val--;
                    end else begin
                        m_fim = 1;
`ifdef AUTO_RELOAD_EN
                        if (m_reload != 0) m_val = m_reload;
                        else begin m_val = 0; m_done = 1; m_run = 0; end
`else
                        m_val = 0; m_done = 1; m_run = 0;
`endif
                    end
                end
            end
        end
    endtask

    // One clock: update model, clock the DUT, compare, then drop the pulses.
    task automatic edge_chk();
        model_edge();
        @(posedge clk);
        #1;
        check("valor", int'(bus.valor), m_val);
        check("fim", int'(bus.fim), int'(m_fim));
        check("rodando", int'(bus.rodando), int'(m_run));
        bus.start = 1'b0;
        bus.pausa = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) edge_chk();
    endtask

    task automatic load(input int v);
        bus.carga = 1'b1;
        bus.valor_carga = 7'(v);
        edge_chk();
        bus.carga = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        edge_chk();
    endtask

    task automatic pulse_pausa();
        bus.pausa = 1'b1;
        edge_chk();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.carga = 1'b0;
        bus.valor_carga = '0;
        bus.start = 1'b0;
        bus.pausa = 1'b0;
        #2;

        // 1: reset, then an ignored start
        idle(2);
        reset = 1'b0;
        check("rst_valor", int'(bus.valor), 0);
        check("rst_fim", int'(bus.fim), 0);
        check("rst_rodando", int'(bus.rodando), 0);
        pulse_start();
        idle(2);
        check("idle_start_valor", int'(bus.valor), 0);
        check("idle_start_rodando", int'(bus.rodando), 0);

`ifndef AUTO_RELOAD_EN
        // 2: load 3, count to zero, then start ignored in FIM
        load(3);
        pulse_start();                          // edge N
        check("t2_rodando", int'(bus.rodando), 1);
        idle(3);
        check("t2_n3", int'(bus.valor), 3);
        idle(1);
        check("t2_n4", int'(bus.valor), 2);
        idle(4);
        check("t2_n8", int'(bus.valor), 1);
        idle(4);
        check("t2_n12_valor", int'(bus.valor), 0);
        check("t2_n12_fim", int'(bus.fim), 1);
        check("t2_n12_rodando", int'(bus.rodando), 0);
        pulse_start();
        pulse_pausa();
        idle(6);
        check("t2_fim_hold", int'(bus.fim), 1);
        check("t2_fim_valor", int'(bus.valor), 0);
        load(7);
        check("t2_carga_clears_fim", int'(bus.fim), 0);
        check("t2_carga_valor", int'(bus.valor), 7);
`endif

        // 3: saturation and start with zero
        load(120);
        check("t3_sat", int'(bus.valor), 99);
        load(99);
        check("t3_99", int'(bus.valor), 99);
        load(0);
        pulse_start();
        idle(5);
        check("t3_zero_rodando", int'(bus.rodando), 0);
        check("t3_zero_valor", int'(bus.valor), 0);

        // 4: pause holds, resume continues the prescaler phase
        load(5);
        pulse_start();                          // N
        idle(4);                                // N+4
        check("t4_n4", int'(bus.valor), 4);
        idle(1);                                // N+5
        pulse_pausa();                          // N+6
        check("t4_paused_rodando", int'(bus.rodando), 0);
        idle(20);
        check("t4_hold", int'(bus.valor), 4);
        pulse_start();                          // M
        check("t4_m_rodando", int'(bus.rodando), 1);
        idle(1);
        check("t4_m1", int'(bus.valor), 4);
        idle(1);
        check("t4_m2", int'(bus.valor), 3);

        // 5: start+pausa together on a tick edge, then carga mid-count
        load(5);
        pulse_start();                          // N
        idle(3);                                // N+3
        bus.start = 1'b1;
        bus.pausa = 1'b1;
        edge_chk();                             // N+4 tick suppressed
        check("t5_no_dec", int'(bus.valor), 5);
        check("t5_paused", int'(bus.rodando), 0);
        idle(10);
        check("t5_hold", int'(bus.valor), 5);
        pulse_start();                          // held phase was last -> tick now
        check("t5_resume_tick", int'(bus.valor), 4);
        idle(2);
        load(9);
        check("t5_carga_valor", int'(bus.valor), 9);
        check("t5_carga_fim", int'(bus.fim), 0);
        check("t5_carga_rodando", int'(bus.rodando), 0);

`ifdef AUTO_RELOAD_EN
        // 6: auto reload
        load(2);
        pulse_start();                          // N
        idle(4);
        check("t6_n4", int'(bus.valor), 1);
        check("t6_n4_fim", int'(bus.fim), 0);
        idle(4);
        check("t6_n8", int'(bus.valor), 2);
        check("t6_n8_fim", int'(bus.fim), 1);
        check("t6_n8_rodando", int'(bus.rodando), 1);
        idle(1);
        check("t6_n9_fim", int'(bus.fim), 0);
        idle(3);
        check("t6_n12", int'(bus.valor), 1);
        check("t6_n12_rodando", int'(bus.rodando), 1);
`endif

        // Random phase against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            bus.carga = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 1) == 0)
                bus.valor_carga = 7'($urandom_range(0, 6));
            else
                bus.valor_carga = 7'($urandom_range(0, 127));
            bus.start = ($urandom_range(0, 5) == 0);
            bus.pausa = ($urandom_range(0, 9) == 0);
            edge_chk();
        end
        reset = 1'b0;
        bus.carga = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
